// File: rtl/activation_scheduler.sv
// activation_scheduler
// Shares one fixed-latency activation unit between the NUM_NEURONS neurons
// of a layer. Pending sums are granted one per cycle. Each granted sum is
// tagged with its neuron index, and the tag is carried alongside the unit's
// latency so the result can be emitted as an indexed stream. o_layer_done
// pulses once every neuron has been serviced exactly once.
//
// Build option: define ACT_SCHED_FIXED_PRIO_EN to select fixed priority
// (lowest eligible index wins, no round-robin pointer). With the macro
// undefined, arbitration is round-robin starting after the last grant.
//
// Handshake: a neuron raises i_sum_valid[k] and holds it together with its
// sum until o_sum_ack[k] pulses for one cycle. A neuron is granted at most
// once per layer, so a request still held during its ack cycle is ignored
// until the layer completes.
//
// Ports:
//   i_clk, i_rst_n  clock (rising edge), asynchronous active-low reset
//   i_sum_valid     per-neuron request
//   i_sum           packed sums, neuron k at [k*2*DATA_WIDTH +: 2*DATA_WIDTH]
//   o_sum_ack       one-hot grant pulse
//   o_act_in        sum presented to the shared activation unit
//   i_act_out       activation unit result, ACT_LATENCY cycles after o_act_in
//   o_out_valid     result valid
//   o_out_idx       neuron index of o_out_data
//   o_out_data      activated result
//   o_layer_done    one-cycle pulse after the last result of a layer
module activation_scheduler #(
  parameter int NUM_NEURONS = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int ACT_LATENCY = 1
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic [NUM_NEURONS-1:0]              i_sum_valid,
  input  logic [NUM_NEURONS*2*DATA_WIDTH-1:0] i_sum,
  output logic [NUM_NEURONS-1:0]              o_sum_ack,
  output logic [2*DATA_WIDTH-1:0]             o_act_in,
  input  logic [DATA_WIDTH-1:0]               i_act_out,
  output logic                                o_out_valid,
  output logic [$clog2(NUM_NEURONS)-1:0]      o_out_idx,
  output logic [DATA_WIDTH-1:0]               o_out_data,
  output logic                                o_layer_done
);

  localparam int IDX_W = $clog2(NUM_NEURONS);
  localparam int CNT_W = $clog2(NUM_NEURONS + 1);
  localparam int SUM_W = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [NUM_NEURONS-1:0] r_served_mask;
  logic [CNT_W-1:0]       r_issued_cnt;
  logic [CNT_W-1:0]       r_result_cnt;
  logic                   r_tag_vld [ACT_LATENCY+1];
  logic [IDX_W-1:0]       r_tag_idx [ACT_LATENCY+1];

  logic [NUM_NEURONS-1:0] w_eligible;
  logic                   w_grant_en;
  logic                   w_clear;
  logic                   w_grant_vld;
  logic [IDX_W-1:0]       w_grant_idx;
  logic [NUM_NEURONS-1:0] w_grant_oh;
  logic [IDX_W-1:0]       w_j;
  logic [SUM_W-1:0]       w_sel_sum;

  assign w_eligible = i_sum_valid & ~r_served_mask;
  assign w_sel_sum  = i_sum[w_grant_idx*SUM_W +: SUM_W];

`ifndef ACT_SCHED_FIXED_PRIO_EN
  // Holds the last granted index; resets to the top index so the first
  // search after reset starts at neuron 0.
  logic [IDX_W-1:0] r_last_grant;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_grant <= IDX_W'(NUM_NEURONS - 1);
    end else if (w_grant_vld) begin
      r_last_grant <= w_grant_idx;
    end
  end
`endif

  // Arbiter: scan candidates in priority order and take the first eligible.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_grant_oh  = '0;
    w_j         = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
`ifdef ACT_SCHED_FIXED_PRIO_EN
      w_j = IDX_W'(i);
`else
      w_j = IDX_W'((int'(r_last_grant) + 1 + i) % NUM_NEURONS);
`endif
      if (w_grant_en && !w_grant_vld && w_eligible[w_j]) begin
        w_grant_vld     = 1'b1;
        w_grant_idx     = w_j;
        w_grant_oh[w_j] = 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (|w_eligible) w_state_nxt = ST_ISSUE;
      ST_ISSUE: if (r_issued_cnt == CNT_W'(NUM_NEURONS)) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (r_result_cnt == CNT_W'(NUM_NEURONS)) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: grants only while collecting a layer; DONE clears the layer.
  always_comb begin
    w_grant_en   = (r_state == ST_IDLE) || (r_state == ST_ISSUE);
    w_clear      = (r_state == ST_DONE);
    o_layer_done = (r_state == ST_DONE);
  end

  // Layer bookkeeping
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_served_mask <= '0;
      r_issued_cnt  <= '0;
      r_result_cnt  <= '0;
    end else if (w_clear) begin
      r_served_mask <= '0;
      r_issued_cnt  <= '0;
      r_result_cnt  <= '0;
    end else begin
      r_served_mask <= r_served_mask | w_grant_oh;
      if (w_grant_vld) r_issued_cnt <= r_issued_cnt + CNT_W'(1);
      if (r_tag_vld[ACT_LATENCY]) r_result_cnt <= r_result_cnt + CNT_W'(1);
    end
  end

  // Grant outputs; o_act_in keeps its last value when nothing is granted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sum_ack <= '0;
      o_act_in  <= '0;
    end else begin
      o_sum_ack <= w_grant_oh;
      if (w_grant_vld) o_act_in <= w_sel_sum;
    end
  end

  // Tag pipeline: entry 0 lines up with o_act_in, entry ACT_LATENCY with
  // i_act_out. The unit itself is not reset, so only these bits say whether
  // i_act_out carries a real result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i <= ACT_LATENCY; i++) begin
        r_tag_vld[i] <= 1'b0;
        r_tag_idx[i] <= '0;
      end
    end else begin
      r_tag_vld[0] <= w_grant_vld;
      r_tag_idx[0] <= w_grant_idx;
      for (int i = 1; i <= ACT_LATENCY; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_idx[i] <= r_tag_idx[i-1];
      end
    end
  end

  // Result stream, registered one cycle after i_act_out.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_out_valid <= 1'b0;
      o_out_idx   <= '0;
      o_out_data  <= '0;
    end else begin
      o_out_valid <= r_tag_vld[ACT_LATENCY];
      if (r_tag_vld[ACT_LATENCY]) begin
        o_out_idx  <= r_tag_idx[ACT_LATENCY];
        o_out_data <= i_act_out;
      end
    end
  end

endmodule
